// File: rtl/clk_gate_ctrl_pkg.sv
// Shared types and elaboration helpers for the ICG enable controller.
package clk_gate_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_ON    = 2'd0,
        ST_COUNT = 2'd1,
        ST_OFF   = 2'd2,
        ST_WAKE  = 2'd3
    } gate_state_e;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

    // Counter width: enough to hold the larger of the two load values, never below 1 bit.
    function automatic int unsigned cnt_width(input int unsigned idle, input int unsigned wake);
        int unsigned w;
        w = $clog2(max_u(idle, wake));
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/clk_gate_ctrl_timer.sv
// Loadable down-counter with zero flag; shared by the idle-count and wake-settle phases.
module clk_gate_ctrl_timer #(
    parameter int unsigned W = 2
) (
    input  logic         clk_i,
    input  logic         rst_n_i,
    input  logic         load_i,
    input  logic         dec_i,
    input  logic [W-1:0] load_val_i,
    output logic         zero_c_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_c_o = (cnt_q == '0);

endmodule

// File: rtl/clk_gate_enable_ctrl.sv
// Idle-timeout enable generator for a library ICG: gates after a quiet period,
// re-enables on activity and acknowledges once the gated clock has settled.
module clk_gate_enable_ctrl
    import clk_gate_ctrl_pkg::*;
#(
    parameter int unsigned IDLE_CYCLES = 16,
    parameter int unsigned WAKE_LAT    = 2,
    parameter int unsigned STAT_W      = 8
) (
    input  logic              CLK,
    input  logic              RN,
    input  logic              WAKE_REQ,
    input  logic              BUSY,
    input  logic              FORCE_ON,
    input  logic              TEST_EN,
    output logic              E,
    output logic              TE,
    output logic              WAKE_ACK,
    output logic [1:0]        STATE,
    output logic [STAT_W-1:0] GATE_CNT
);

    localparam int unsigned CNT_W = cnt_width(IDLE_CYCLES, WAKE_LAT);

    if (IDLE_CYCLES == 0 || WAKE_LAT == 0 || STAT_W == 0) begin : g_bad_param
        $error("clk_gate_enable_ctrl: IDLE_CYCLES, WAKE_LAT and STAT_W must all be >= 1");
    end

    gate_state_e       state_q;
    gate_state_e       state_d;
    logic              e_q;
    logic              e_d;
    logic              ack_q;
    logic              ack_d;
    logic [STAT_W-1:0] gate_cnt_q;
    logic [STAT_W-1:0] gate_cnt_d;

    logic              activity;
    logic              tmr_load;
    logic              tmr_dec;
    logic [CNT_W-1:0]  tmr_load_val;
    logic              tmr_zero;
    logic              gate_evt;

    assign activity = WAKE_REQ | BUSY | FORCE_ON;

    clk_gate_ctrl_timer #(
        .W (CNT_W)
    ) u_timer (
        .clk_i      (CLK),
        .rst_n_i    (RN),
        .load_i     (tmr_load),
        .dec_i      (tmr_dec),
        .load_val_i (tmr_load_val),
        .zero_c_o   (tmr_zero)
    );

    // Next state, timer control and next values for the output flops.
    always_comb begin
        state_d      = state_q;
        tmr_load     = 1'b0;
        tmr_dec      = 1'b0;
        tmr_load_val = '0;
        gate_evt     = 1'b0;
        gate_cnt_d   = gate_cnt_q;

        unique case (state_q)
            ST_ON: begin
                if (!activity) begin
                    state_d      = ST_COUNT;
                    tmr_load     = 1'b1;
                    tmr_load_val = CNT_W'(IDLE_CYCLES - 1);
                end
            end
            ST_COUNT: begin
                if (activity) begin
                    state_d = ST_ON;
                end else if (tmr_zero) begin
                    state_d  = ST_OFF;
                    gate_evt = 1'b1;
                end else begin
                    tmr_dec = 1'b1;
                end
            end
            ST_OFF: begin
                if (activity) begin
                    state_d      = ST_WAKE;
                    tmr_load     = 1'b1;
                    tmr_load_val = CNT_W'(WAKE_LAT - 1);
                end
            end
            ST_WAKE: begin
                // Wake always runs to completion, even if the request drops.
                if (tmr_zero) begin
                    state_d = ST_ON;
                end else begin
                    tmr_dec = 1'b1;
                end
            end
            default: state_d = ST_ON;
        endcase

        if (gate_evt && (gate_cnt_q != '1)) begin
            gate_cnt_d = gate_cnt_q + STAT_W'(1);
        end

        // E and ACK are decoded from the next state so they stay pure flop outputs.
        e_d   = (state_d != ST_OFF);
        ack_d = (state_d == ST_ON) || (state_d == ST_COUNT);
    end

    always_ff @(posedge CLK or negedge RN) begin
        if (!RN) begin
            state_q    <= ST_ON;
            e_q        <= 1'b1;
            ack_q      <= 1'b1;
            gate_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            e_q        <= e_d;
            ack_q      <= ack_d;
            gate_cnt_q <= gate_cnt_d;
        end
    end

    assign E        = e_q;
    assign WAKE_ACK = ack_q;
    assign STATE    = state_q;
    assign GATE_CNT = gate_cnt_q;
    assign TE       = TEST_EN;

endmodule

// File: tb/tb_clk_gate_enable_ctrl.sv
// Directed bench for clk_gate_enable_ctrl with IDLE_CYCLES=4, WAKE_LAT=2, STAT_W=2.
module tb_clk_gate_enable_ctrl;

    logic       CLK;
    logic       RN;
    logic       WAKE_REQ;
    logic       BUSY;
    logic       FORCE_ON;
    logic       TEST_EN;
    logic       E;
    logic       TE;
    logic       WAKE_ACK;
    logic [1:0] STATE;
    logic [1:0] GATE_CNT;

    int n_pass;
    int n_total;

    clk_gate_enable_ctrl #(
        .IDLE_CYCLES (4),
        .WAKE_LAT    (2),
        .STAT_W      (2)
    ) dut (
        .CLK      (CLK),
        .RN       (RN),
        .WAKE_REQ (WAKE_REQ),
        .BUSY     (BUSY),
        .FORCE_ON (FORCE_ON),
        .TEST_EN  (TEST_EN),
        .E        (E),
        .TE       (TE),
        .WAKE_ACK (WAKE_ACK),
        .STATE    (STATE),
        .GATE_CNT (GATE_CNT)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk_out(input string tag, input logic [1:0] st, input logic e,
                           input logic ack, input logic [1:0] gc);
        chk({tag, ".state"}, 8'(STATE), 8'(st));
        chk({tag, ".e"}, 8'(E), 8'(e));
        chk({tag, ".ack"}, 8'(WAKE_ACK), 8'(ack));
        chk({tag, ".gcnt"}, 8'(GATE_CNT), 8'(gc));
    endtask

    initial begin
        n_pass   = 0;
        n_total  = 0;
        RN       = 1'b0;
        WAKE_REQ = 1'b0;
        BUSY     = 1'b0;
        FORCE_ON = 1'b0;
        TEST_EN  = 1'b0;

        #12;
        chk_out("reset", 2'd0, 1'b1, 1'b1, 2'd0);
        chk("reset.te", 8'(TE), 8'd0);
        RN = 1'b1;

        // Quiet from edge 0; BUSY at edge 4 beats expiry.
        tick();
        chk_out("e0", 2'd1, 1'b1, 1'b1, 2'd0);
        repeat (3) tick();
        chk_out("e3", 2'd1, 1'b1, 1'b1, 2'd0);
        BUSY = 1'b1;
        tick();
        chk_out("late_busy", 2'd0, 1'b1, 1'b1, 2'd0);
        BUSY = 1'b0;

        // Quiet first sampled at edge 5 -> gate after edge 9.
        repeat (4) tick();
        chk_out("e8", 2'd1, 1'b1, 1'b1, 2'd0);
        tick();
        chk_out("gate1", 2'd2, 1'b0, 1'b0, 2'd1);

        // TE is a zero-latency copy; FSM unaffected.
        TEST_EN = 1'b1;
        #1;
        chk("te_hi", 8'(TE), 8'd1);
        tick();
        chk_out("te_off", 2'd2, 1'b0, 1'b0, 2'd1);
        TEST_EN = 1'b0;
        #1;
        chk("te_lo", 8'(TE), 8'd0);

        // Single-edge wake request still completes.
        WAKE_REQ = 1'b1;
        tick();
        chk_out("wake_w", 2'd3, 1'b1, 1'b0, 2'd1);
        WAKE_REQ = 1'b0;
        tick();
        chk_out("wake_w1", 2'd3, 1'b1, 1'b0, 2'd1);
        tick();
        chk_out("wake_w2", 2'd0, 1'b1, 1'b1, 2'd1);
        repeat (4) tick();
        chk_out("wake_w6", 2'd1, 1'b1, 1'b1, 2'd1);
        tick();
        chk_out("gate2", 2'd2, 1'b0, 1'b0, 2'd2);

        // Held FORCE_ON wakes and keeps the clock on.
        FORCE_ON = 1'b1;
        tick();
        chk_out("force_w", 2'd3, 1'b1, 1'b0, 2'd2);
        repeat (2) tick();
        chk_out("force_w2", 2'd0, 1'b1, 1'b1, 2'd2);
        tick();
        chk_out("force_hold", 2'd0, 1'b1, 1'b1, 2'd2);
        FORCE_ON = 1'b0;
        repeat (4) tick();
        chk_out("force_cnt", 2'd1, 1'b1, 1'b1, 2'd2);
        tick();
        chk_out("gate3", 2'd2, 1'b0, 1'b0, 2'd3);

        // Counter saturates at all-ones.
        WAKE_REQ = 1'b1;
        tick();
        WAKE_REQ = 1'b0;
        repeat (2) tick();
        chk_out("sat_on", 2'd0, 1'b1, 1'b1, 2'd3);
        repeat (5) tick();
        chk_out("gate_sat", 2'd2, 1'b0, 1'b0, 2'd3);

        // Async reset mid-WAKE, checked before the next edge.
        WAKE_REQ = 1'b1;
        tick();
        chk_out("pre_rst_wake", 2'd3, 1'b1, 1'b0, 2'd3);
        WAKE_REQ = 1'b0;
        #3;
        RN = 1'b0;
        #1;
        chk_out("rst_wake", 2'd0, 1'b1, 1'b1, 2'd0);
        #2;
        RN = 1'b1;

        // Async reset mid-COUNT.
        tick();
        chk_out("pre_rst_cnt", 2'd1, 1'b1, 1'b1, 2'd0);
        #3;
        RN = 1'b0;
        #1;
        chk_out("rst_cnt", 2'd0, 1'b1, 1'b1, 2'd0);
        #2;
        RN = 1'b1;
        tick();
        chk_out("post_rst", 2'd1, 1'b1, 1'b1, 2'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
